// File: rtl/blockmem_access_ctrl_if.sv
// Request/response bundle between the load/store datapath (master) and blockmem_access_ctrl (slave).
interface blockmem_access_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );
endinterface

// File: rtl/blockmem_access_ctrl.sv
// Single-outstanding front end for a 1-cycle-read block RAM: response 2 edges (store) / 3 edges (load) after accept, held until rsp_ready.
// Optional MEM_BOUNDS_CHECK_EN: requests at or above MEM_WORDS skip the RAM and answer rsp_err after 1 edge.
module blockmem_access_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 2048
) (
  input  logic                   clka,
  input  logic                   rst_n,
  blockmem_access_ctrl_if.slave  bus,
  output logic                   mem_wea,
  output logic [ADDR_W-1:0]      mem_addra,
  output logic [DATA_W-1:0]      mem_dina,
  input  logic [DATA_W-1:0]      mem_douta,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state, state_nxt;
  logic              wea_nxt;
  logic [ADDR_W-1:0] addra_nxt;
  logic [DATA_W-1:0] dina_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic              rsp_we_q, rsp_we_nxt;
  logic              rsp_err_q, rsp_err_nxt;
  logic              oob;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = 32'(bus.req_addr) >= 32'(MEM_WORDS);
`else
  logic unused_mem_words;
  assign oob              = 1'b0;
  assign unused_mem_words = ^MEM_WORDS;
`endif

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_wea     <= 1'b0;
      mem_addra   <= '0;
      mem_dina    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_wea     <= wea_nxt;
      mem_addra   <= addra_nxt;
      mem_dina    <= dina_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_we_q    <= rsp_we_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  // RAM address/data hold their last value; only the write enable is a one-cycle pulse.
  always_comb begin
    state_nxt     = state;
    wea_nxt       = 1'b0;
    addra_nxt     = mem_addra;
    dina_nxt      = mem_dina;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_we_nxt    = rsp_we_q;
    rsp_err_nxt   = rsp_err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          rsp_we_nxt  = bus.req_we;
          rsp_err_nxt = oob;
          if (oob) begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            state_nxt     = RESP;
          end else begin
            addra_nxt = bus.req_addr;
            dina_nxt  = bus.req_wdata;
            wea_nxt   = bus.req_we;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rsp_we_q) begin
          rsp_rdata_nxt = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      // RAM output register is valid one edge after the read was issued.
      CAPTURE: begin
        rsp_rdata_nxt = mem_douta;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_blockmem_access_ctrl.sv
// Bench for blockmem_access_ctrl: behavioural RAM, latency/transaction model checked every cycle, directed then random traffic.
module tb_blockmem_access_ctrl;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 1024;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic              clka = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_wea;
  logic              busy;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;

  blockmem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  blockmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_douta (mem_douta),
    .busy      (busy)
  );

  always #5 clka = ~clka;

  function automatic logic [15:0] init_val(input int i);
    return 16'(32'h1000 + i);
  endfunction

  // Block RAM: registered read-first output, write on wea.
  logic [15:0] ram [2048];
  initial begin
    mem_douta = '0;
    for (int i = 0; i < 2048; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clka);
      mem_douta <= ram[mem_addra];
      if (mem_wea) ram[mem_addra] = mem_dina;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory plus a countdown to the response edge.
  logic [15:0]       m_mem [2048];
  bit                m_busy, m_rsp_vld, m_rsp_we, m_rsp_err, m_wea;
  int                m_cnt;
  int                m_hs = 0;
  logic [15:0]       m_rsp_dat, m_dina;
  logic [ADDR_W-1:0] m_addra, m_rd_addr;

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_rsp_vld = 0; m_rsp_dat = '0; m_rsp_we = 0;
    m_rsp_err = 0; m_wea = 0; m_addra = '0; m_dina = '0; m_rd_addr = '0;
  endtask

  task automatic model_step();
    bit oob;
    if (m_wea) m_mem[m_addra] = m_dina;
    m_wea = 0;
    if (!m_busy) begin
      if (ifc.req_valid) begin
        oob       = BCHK && (int'(ifc.req_addr) >= MEM_WORDS);
        m_busy    = 1;
        m_rsp_we  = ifc.req_we;
        m_rsp_err = oob;
        if (oob) begin
          m_cnt = 0; m_rsp_vld = 1; m_rsp_dat = '0;
        end else begin
          m_addra = ifc.req_addr; m_dina = ifc.req_wdata; m_wea = ifc.req_we;
          m_rd_addr = ifc.req_addr;
          m_cnt = ifc.req_we ? 1 : 2;
        end
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_rsp_vld = 1;
        m_rsp_dat = m_rsp_we ? 16'h0 : m_mem[m_rd_addr];
      end
    end else if (ifc.rsp_ready) begin
      m_rsp_vld = 0; m_busy = 0; m_hs++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) m_mem[i] = init_val(i);
    model_reset();
    forever begin
      @(posedge clka or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  int dut_hs = 0;
  initial forever begin
    @(posedge clka);
    if (rst_n && ifc.rsp_valid && ifc.rsp_ready) dut_hs++;
  end

  initial forever begin
    @(negedge clka);
    if (chk_en) begin
      chk("req_ready", 32'(ifc.req_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_wea", 32'(mem_wea), 32'(m_wea));
      chk("mem_addra", 32'(mem_addra), 32'(m_addra));
      chk("mem_dina", 32'(mem_dina), 32'(m_dina));
      chk("rsp_valid", 32'(ifc.rsp_valid), 32'(m_rsp_vld));
      if (m_rsp_vld) begin
        chk("rsp_rdata", 32'(ifc.rsp_rdata), 32'(m_rsp_dat));
        chk("rsp_we", 32'(ifc.rsp_we), 32'(m_rsp_we));
        chk("rsp_err", 32'(ifc.rsp_err), 32'(m_rsp_err));
      end
    end
  end

  // Present a request and hold it until accepted; waits = edges from call to the accept edge.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] d, output int waits);
    bit rdy = 1'b0;
    waits = 0;
    ifc.req_valid = 1'b1; ifc.req_we = we; ifc.req_addr = a; ifc.req_wdata = d;
    for (int i = 0; i < 40; i++) begin
      rdy = ifc.req_ready;
      @(negedge clka);
      waits++;
      if (rdy) break;
    end
    chk("req_accept_timeout", 32'(rdy), 32'd1);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [15:0] d, output int lat);
    lat = 1;
    for (int i = 0; i < 40 && !ifc.rsp_valid; i++) begin
      @(negedge clka);
      lat++;
    end
    chk("rsp_timeout", 32'(ifc.rsp_valid), 32'd1);
    d = ifc.rsp_rdata;
  endtask

  int          w, lat;
  logic [15:0] d;
  bit          rdy_prev;

  initial begin
    ifc.req_valid = 0; ifc.req_we = 0; ifc.req_addr = '0; ifc.req_wdata = '0; ifc.rsp_ready = 0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk_en = 1'b1;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_mem_wea", 32'(mem_wea), 32'd0);
    chk("rst_mem_addra", 32'(mem_addra), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Store 13 to address 5.
    do_req(1'b1, 11'd5, 16'd13, w);
    chk("st_wea_on", 32'(mem_wea), 32'd1);
    chk("st_addra", 32'(mem_addra), 32'd5);
    chk("st_dina", 32'(mem_dina), 32'd13);
    chk("st_rsp_early", 32'(ifc.rsp_valid), 32'd0);
    @(negedge clka);
    chk("st_wea_off", 32'(mem_wea), 32'd0);
    chk("st_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("st_rsp_we", 32'(ifc.rsp_we), 32'd1);
    chk("st_rsp_rdata", 32'(ifc.rsp_rdata), 32'd0);
    ifc.rsp_ready = 1'b1;
    @(negedge clka);
    chk("st_idle", 32'(ifc.req_ready), 32'd1);
    ifc.rsp_ready = 1'b0;

    // Load address 5 with the consumer stalled for 5 cycles.
    do_req(1'b0, 11'd5, 16'd0, w);
    chk("ld_v0", 32'(ifc.rsp_valid), 32'd0);
    @(negedge clka);
    chk("ld_v1", 32'(ifc.rsp_valid), 32'd0);
    @(negedge clka);
    chk("ld_v2", 32'(ifc.rsp_valid), 32'd1);
    chk("ld_data", 32'(ifc.rsp_rdata), 32'd13);
    chk("ld_rsp_we", 32'(ifc.rsp_we), 32'd0);
    repeat (5) begin
      @(negedge clka);
      chk("bp_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("bp_data", 32'(ifc.rsp_rdata), 32'd13);
      chk("bp_req_ready", 32'(ifc.req_ready), 32'd0);
      chk("bp_wea", 32'(mem_wea), 32'd0);
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clka);
    chk("bp_release_ready", 32'(ifc.req_ready), 32'd1);
    chk("bp_release_valid", 32'(ifc.rsp_valid), 32'd0);

    // Back-to-back requests held while busy.
    do_req(1'b0, 11'd5, 16'd0, w);
    do_req(1'b1, 11'd7, 16'h0077, w);
    chk("spacing_after_load", 32'(w), 32'd4);
    do_req(1'b1, 11'd8, 16'h0088, w);
    chk("spacing_after_store", 32'(w), 32'd3);
    repeat (4) @(negedge clka);

    // Reset while a store is on the RAM port.
    do_req(1'b1, 11'd9, 16'hBEEF, w);
    chk("mid_rst_wea_before", 32'(mem_wea), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wea_async", 32'(mem_wea), 32'd0);
    chk("mid_rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(ifc.req_ready), 32'd1);
    @(negedge clka);
    rst_n = 1'b1;
    do_req(1'b0, 11'd9, 16'd0, w);
    wait_rsp(d, lat);
    chk("mid_rst_old_value", 32'(d), 32'h1009);
    chk("load_latency", 32'(lat), 32'd3);
    do_req(1'b1, 11'd9, 16'hBEEF, w);
    wait_rsp(d, lat);
    chk("store_latency", 32'(lat), 32'd2);
    do_req(1'b0, 11'd9, 16'd0, w);
    wait_rsp(d, lat);
    chk("load_after_store", 32'(d), 32'hBEEF);
    repeat (3) @(negedge clka);

`ifdef MEM_BOUNDS_CHECK_EN
    ifc.rsp_ready = 1'b0;
    do_req(1'b1, 11'd1500, 16'h1234, w);
    chk("oob_wea", 32'(mem_wea), 32'd0);
    chk("oob_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("oob_err", 32'(ifc.rsp_err), 32'd1);
    chk("oob_rdata", 32'(ifc.rsp_rdata), 32'd0);
    chk("oob_addra_kept", 32'(mem_addra), 32'd9);
    ifc.rsp_ready = 1'b1;
    @(negedge clka);
    do_req(1'b1, 11'd1000, 16'h4321, w);
    chk("inb_wea", 32'(mem_wea), 32'd1);
    @(negedge clka);
    chk("inb_valid", 32'(ifc.rsp_valid), 32'd1);
    chk("inb_err", 32'(ifc.rsp_err), 32'd0);
    repeat (3) @(negedge clka);
`endif

    // Random traffic; an unaccepted request is held unchanged.
    rdy_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      if (!(ifc.req_valid && !rdy_prev)) begin
        ifc.req_valid = ($urandom_range(0, 2) == 0);
        ifc.req_we    = 1'($urandom_range(0, 1));
        ifc.req_addr  = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
        ifc.req_wdata = 16'($urandom);
      end
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      rdy_prev = ifc.req_ready;
    end
    @(negedge clka);
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    repeat (10) @(negedge clka);
    chk("rsp_handshakes", 32'(dut_hs), 32'(m_hs));
    chk("rsp_handshakes_enough", 32'(m_hs > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
